// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester packet arbiter.
package mux_arb_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

endpackage

// File: rtl/MUX2_1.sv
// Library 2:1 mux cell: o_y follows i_b when i_sel is high, else i_a.
module MUX2_1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_arbiter2.sv
// Packet-locked round-robin arbiter for two valid/ready requesters feeding
// one registered output stage; data is steered through per-bit MUX2_1 cells.
module mux_arbiter2
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [1:0]       in_last,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic [1:0]       grant
);

  state_e           r_state;
  logic             r_prio;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;

  logic             w_own0;
  logic             w_own1;
  logic             w_sel;
  logic             w_drain_ok;
  logic [1:0]       w_ready;
  logic             w_xfer;
  logic             w_last;
  logic [WIDTH-1:0] w_data;

  assign w_own0     = (r_state == OWN0);
  assign w_own1     = (r_state == OWN1);
  assign w_sel      = w_own1;
  // The output slot can take a beat if it is empty or is draining this edge.
  assign w_drain_ok = !r_out_valid || out_ready;
  assign w_ready    = {w_own1 & w_drain_ok, w_own0 & w_drain_ok};
  assign w_xfer     = |(in_valid & w_ready);
  assign w_last     = w_sel ? in_last[1] : in_last[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    MUX2_1 u_mux (
      .i_a   (in_data0[i]),
      .i_b   (in_data1[i]),
      .i_sel (w_sel),
      .o_y   (w_data[i])
    );
  end

  // Arbitration FSM, round-robin pointer and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          case (in_valid)
            2'b01: begin
              r_state <= OWN0;
              r_prio  <= 1'b1;
            end
            2'b10: begin
              r_state <= OWN1;
              r_prio  <= 1'b0;
            end
            2'b11: begin
              r_state <= r_prio ? OWN1 : OWN0;
              r_prio  <= ~r_prio;
            end
            default: ;
          endcase
        end
        OWN0, OWN1: begin
          if (w_xfer && w_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_last  <= w_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign sel       = w_sel;
  assign grant     = {w_own1, w_own0};

endmodule

// File: tb/tb_mux_arbiter2.sv
// Directed bench for mux_arbiter2: per-cycle model compare plus literal checks.
module tb_mux_arbiter2;

  logic       clk;
  logic       rst;
  logic       v0, v1, l0, l1;
  logic [1:0] in_valid;
  logic [1:0] in_last;
  logic [7:0] in_data0, in_data1;
  logic [1:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       sel;
  logic [1:0] grant;

  int errors = 0;
  int checks = 0;
  bit run = 0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  // Model state: owner -1 means nobody owns the output.
  int         m_owner;
  int         m_prio;
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_ol;

  assign in_valid = {v1, v0};
  assign in_last  = {l1, l0};

  mux_arbiter2 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Behavioural model: who owns the output, whose turn a tie is, and what sits in the slot.
  always @(posedge clk or posedge rst) begin : model
    int   pick;
    logic room;
    if (rst) begin
      m_owner <= -1;
      m_prio  <= 0;
      m_ov    <= 1'b0;
      m_od    <= 8'h00;
      m_ol    <= 1'b0;
    end else if (m_owner < 0) begin
      if (in_valid != 2'b00) begin
        if (in_valid == 2'b11) pick = m_prio;
        else pick = in_valid[1] ? 1 : 0;
        m_owner <= pick;
        m_prio  <= 1 - pick;
      end
      if (m_ov && out_ready) m_ov <= 1'b0;
    end else begin
      room = !m_ov || out_ready;
      if (in_valid[m_owner] && room) begin
        m_ov <= 1'b1;
        m_od <= (m_owner == 1) ? in_data1 : in_data0;
        m_ol <= in_last[m_owner];
        if (in_last[m_owner]) m_owner <= -1;
      end else if (m_ov && out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  // Compare process: all outputs against the model, plus the drained-beat log.
  always @(negedge clk) begin : cmp
    logic [1:0] er;
    logic [1:0] eg;
    logic       es;
    if (out_valid === 1'b1 && out_ready === 1'b1) log_q.push_back(out_data);
    if (run) begin
      er = 2'b00;
      if (m_owner >= 0 && (!m_ov || out_ready)) er[m_owner] = 1'b1;
      eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      es = (m_owner == 1);
      checks++;
      if ({in_ready, out_valid, out_data, out_last, sel, grant} !==
          {er, m_ov, m_od, m_ol, es, eg}) begin
        errors++;
        $display("FAIL cycle t=%0t: got rdy=%b ov=%b od=%h ol=%b sel=%b gnt=%b, want rdy=%b ov=%b od=%h ol=%b sel=%b gnt=%b",
                 $time, in_ready, out_valid, out_data, out_last, sel, grant,
                 er, m_ov, m_od, m_ol, es, eg);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  // Drive an n-beat packet on requester r holding each beat until accepted.
  task automatic send(input int r, input logic [7:0] first, input int n);
    int budget;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      if (r == 0) begin
        v0 = 1'b1; in_data0 = first + 8'(i); l0 = (i == n - 1);
      end else begin
        v1 = 1'b1; in_data1 = first + 8'(i); l1 = (i == n - 1);
      end
      while (in_ready[r] !== 1'b1 && budget < 40) begin
        next();
        budget++;
      end
      if (budget >= 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: requester %0d beat %0d got no in_ready, expected within 40 cycles", r, i);
      end
      next();
    end
    if (r == 0) begin v0 = 1'b0; l0 = 1'b0; end
    else begin v1 = 1'b0; l1 = 1'b0; end
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    in_data0 = 8'h00; in_data1 = 8'h00;
    out_ready = 1'b1;
    next();
    run = 1'b1;
    repeat (2) next();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);

    // Single beat from requester 0
    rst = 1'b0;
    v0 = 1'b1; in_data0 = 8'hA5; l0 = 1'b1;
    next();
    chk("single_grant_c1", 32'(grant), 32'h1);
    chk("single_in_ready_c1", 32'(in_ready), 32'h1);
    chk("single_out_valid_c1", 32'(out_valid), 32'h0);
    next();
    v0 = 1'b0; l0 = 1'b0;
    chk("single_out_valid_c2", 32'(out_valid), 32'h1);
    chk("single_out_data_c2", 32'(out_data), 32'hA5);
    chk("single_out_last_c2", 32'(out_last), 32'h1);
    chk("single_idle_c2", 32'(grant), 32'h0);
    repeat (2) next();

    // Alternating ties after a fresh reset
    rst = 1'b1;
    next();
    rst = 1'b0;
    log_q.delete();
    fork
      repeat (2) send(0, 8'h11, 1);
      repeat (2) send(1, 8'h22, 1);
    join
    repeat (3) next();
    exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
    chk_log("alternate");

    // Packet lock: 4 beats from requester 0 while requester 1 waits
    log_q.delete();
    fork
      send(0, 8'h01, 4);
      send(1, 8'h22, 1);
    join
    repeat (3) next();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h22};
    chk_log("lock");

    // Backpressure for 3 cycles mid-packet
    log_q.delete();
    fork
      send(0, 8'h31, 4);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          chk($sformatf("stall_data_%0d", k), 32'(out_data), 32'h32);
          chk($sformatf("stall_ready_%0d", k), 32'(in_ready), 32'h0);
          if (k == 2) out_ready = 1'b1;
        end
      end
    join
    repeat (3) next();
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    chk_log("stall");

    // Reset during beat 2 of a 4-beat packet, then a tie
    log_q.delete();
    v0 = 1'b1; in_data0 = 8'h41; l0 = 1'b0;
    next();
    next();
    in_data0 = 8'h42;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    v0 = 1'b1; in_data0 = 8'hA0; l0 = 1'b1;
    v1 = 1'b1; in_data1 = 8'hB1; l1 = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    next();
    chk("midrst_tie_grant", 32'(grant), 32'h1);
    next();
    v0 = 1'b0; l0 = 1'b0;
    next();
    chk("midrst_second_grant", 32'(grant), 32'h2);
    next();
    v1 = 1'b0; l1 = 1'b0;
    repeat (3) next();
    exp_q = '{8'hA0, 8'hB1};
    chk_log("midrst");

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
